debug_flag_port: RTL
====================

// Module: debug_flag_port
// PURPOSE
//  Avalon-MM slave in the pulpino Qsys system that the RISC-V core writes test
//  flags to ({status[31:24], location[23:16], id[15:8], step[7:0]}), driving the
//  top-level debug_wire probed by the simulation bench. Writes are queued in a FIFO
//  and each value is displayed for at least MIN_HOLD clocks, so back-to-back flag /
//  value writes from firmware (e.g. ISR step 01 then step 02) are never lost to
//  bench sampling. The last value displayed stays on debug_wire indefinitely.
// PARAMETERS
//  DATA_W    32  width of flag word and Avalon data bus
//  DEPTH     8   FIFO entries (power of 2, >=2)
//  MIN_HOLD  4   minimum clocks each value stays on debug_wire (>=1)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  address      in   2       word address: 0 FLAG, 1 STATUS, 2 CTRL
//  write        in   1       Avalon write strobe
//  writedata    in   DATA_W  write data
//  read         in   1       Avalon read strobe
//  readdata     out  DATA_W  read data, readLatency = 1
//  waitrequest  out  1       stall for a write to FLAG while the FIFO is full
//  debug_wire   out  DATA_W  currently displayed flag word
// BEHAVIOUR
//  Reset (async): debug_wire=0, readdata=0, FIFO empty, hold counter=0, FSM=IDLE.
//  Register map:
//   FLAG  wr: push writedata; rd: current debug_wire value.
//   STATUS rd: [7:0] FIFO count (entries queued, excluding the displayed value),
//          [8] full, [9] busy (FSM=HOLD); other bits 0. Writes are ignored.
//   CTRL  wr bit0=1: flush FIFO (count->0). debug_wire and FSM are unchanged.
//          rd returns 0.
//  waitrequest = write & (address==0) & full. It is combinational from full only,
//   not from a same-cycle pop. A stalled write completes in the first cycle after
//   full drops. Other accesses never stall.
//  readdata is registered: valid the cycle after read is asserted and is 0 otherwise.
//  Push is accepted when write & address==0 & !full. Push and pop in the same cycle
//   are both allowed when not full; count is unchanged.
//  Display FSM:
//   IDLE: if FIFO is non-empty, pop the head; debug_wire<=head on the next edge;
//         cnt<=MIN_HOLD-1; ->HOLD.
//   HOLD: if cnt!=0 then cnt--.
//         If cnt==0 and the FIFO is non-empty, pop; debug_wire<=head;
//         cnt<=MIN_HOLD-1; stay in HOLD.
//         If cnt==0 and the FIFO is empty, ->IDLE (debug_wire held).
//  Latency: a write accepted at edge N with an empty FIFO in IDLE makes the FIFO
//   non-empty at N, pops at N+1, and the value is visible on debug_wire after
//   edge N+2. Each value is shown for exactly MIN_HOLD clocks while successors
//   are queued.
//  A flush during HOLD finishes the current hold and then returns to IDLE.
//  A flush and a push in the same cycle are not possible (different addresses).
//  Pointers wrap modulo DEPTH. Count has width clog2(DEPTH)+1 and is reported
//   zero-extended.
//  Reset asserted mid-operation clears everything immediately. There is no partial
//   output.
// TESTING
//  1 Reset: release reset -> debug_wire=0, STATUS read=0, waitrequest=0.
//  2 Single write 0x00010000 to FLAG in IDLE -> debug_wire=0x00010000 two clocks
//    after accept, held >=100 clocks; FLAG read returns 0x00010000.
//  3 Back-to-back writes 0x00040300, 0x00040301, 0x00040302 (MIN_HOLD=4) ->
//    debug_wire shows each of the first two values for exactly 4 clocks, then the
//    third indefinitely.
//  4 Ten back-to-back writes, DEPTH=8 -> waitrequest high on the 10th write until
//    the first pop after the hold; all 10 values appear in order with none
//    dropped. STATUS shows full=1 during the stall.
//  5 Three values queued, then CTRL write 0x1 -> STATUS count=0, the current value
//    holds, FSM returns to IDLE, and no queued value appears.
//  6 Assert reset during HOLD with 3 values queued -> debug_wire=0 and STATUS=0
//    immediately. A new write after release displays in 2 clocks.

Source files
------------

// File: rtl/debug_flag_if.sv
// debug_flag_if: Avalon-MM bus bundle for the debug flag port.
//   address     [1:0]      word address (0 FLAG, 1 STATUS, 2 CTRL)
//   write                  write strobe
//   writedata   [DATA_W]   write data
//   read                   read strobe
//   readdata    [DATA_W]   registered read data, one-cycle read latency
//   waitrequest            stalls a FLAG write while the FIFO is full
// The master modport is the CPU side, the slave modport is the port block.
interface debug_flag_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/debug_flag_port.sv
// debug_flag_port: firmware test-flag port driving debug_wire.
// Flag words written to FLAG are queued in a FIFO and shown one at a time on
// debug_wire, each for at least MIN_HOLD clocks, so a bench sampling the wire
// never misses a back-to-back update. The last shown value stays indefinitely.
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   bus         Avalon-MM slave (address/write/writedata/read/readdata/waitrequest)
//   debug_wire  flag word currently displayed
// Register map: 0 FLAG (wr push, rd displayed value), 1 STATUS (rd
// {busy, full, count[7:0]}), 2 CTRL (wr bit0 flushes the queue, rd 0).
module debug_flag_port #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int MIN_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  debug_flag_if.slave       bus,
  output logic [DATA_W-1:0] debug_wire
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD - 1);
  localparam logic [1:0] ADDR_FLAG   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  // Popped head waits one cycle in stage_q before reaching debug_wire.
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic [DATA_W-1:0] debug_q, debug_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              full_s, empty_s, busy_s, push_s, pop_s, flush_s;
  logic [DATA_W-1:0] status_s;

  // Access decode, display FSM next state, FIFO bookkeeping and read mux.
  always_comb begin
    full_s  = (count_q == CNT_W'(DEPTH));
    empty_s = (count_q == {CNT_W{1'b0}});
    busy_s  = (state_q == HOLD);
    push_s  = bus.write && (bus.address == ADDR_FLAG) && !full_s;
    flush_s = bus.write && (bus.address == ADDR_CTRL) && bus.writedata[0];

    // A flush suppresses any pop in the same cycle so no discarded entry is shown.
    pop_s   = 1'b0;
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (!empty_s && !flush_s) begin
          pop_s   = 1'b1;
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_q != {HOLD_W{1'b0}}) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (!empty_s && !flush_s) begin
          pop_s  = 1'b1;
          hold_d = HOLD_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = {HOLD_W{1'b0}};
      end
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      // Flush and push use different addresses, so they never coincide.
      count_d  = {CNT_W{1'b0}};
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    stage_vld_d = pop_s;
    if (pop_s) begin
      stage_d = mem_q[rd_ptr_q];
    end else begin
      stage_d = stage_q;
    end
    if (stage_vld_q) begin
      debug_d = stage_q;
    end else begin
      debug_d = debug_q;
    end

    status_s      = {DATA_W{1'b0}};
    status_s[7:0] = 8'(count_q);
    status_s[8]   = full_s;
    status_s[9]   = busy_s;

    rdata_d = {DATA_W{1'b0}};
    if (bus.read) begin
      case (bus.address)
        ADDR_FLAG:   rdata_d = debug_q;
        ADDR_STATUS: rdata_d = status_s;
        default:     rdata_d = {DATA_W{1'b0}};
      endcase
    end else begin
      rdata_d = {DATA_W{1'b0}};
    end
  end

  // Stall depends only on the registered full flag, never on a same-cycle pop.
  assign bus.waitrequest = bus.write && (bus.address == ADDR_FLAG) && full_s;
  assign bus.readdata    = rdata_q;
  assign debug_wire      = debug_q;

  // Control, display and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      state_q     <= IDLE;
      hold_q      <= {HOLD_W{1'b0}};
      stage_q     <= {DATA_W{1'b0}};
      stage_vld_q <= 1'b0;
      debug_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      debug_q     <= debug_d;
      rdata_q     <= rdata_d;
    end
  end

  // FIFO storage; entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.writedata;
    end
  end

endmodule
